// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_SIGN = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement of a W-bit value.
module mdu_negate #(
  parameter int unsigned W = 32
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = en ? (~a + W'(1)) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// Optional macro MULT_DIV_EARLY_OUT_EN skips iteration for zero operands / zero divisor.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_wen,
  input  logic         lo_wen,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = $clog2(N);

  mdu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           div_q, div_d;
  logic           psign_q, psign_d;  // product / quotient sign
  logic           rsign_q, rsign_d;  // remainder sign
  logic           divz_q, divz_d;
  logic [N-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [N-1:0]   acc_hi_q, acc_hi_d;
  logic [N-1:0]   acc_lo_q, acc_lo_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  logic [N-1:0]   abs_a, abs_b, rem_fix, quo_fix;
  logic [2*N-1:0] prod_fix;
  logic [N:0]     mul_sum, div_shift, div_diff;

  mdu_negate #(.W(N)) u_abs_a (.en(op[0] & inA[N-1]), .a(inA), .y(abs_a));
  mdu_negate #(.W(N)) u_abs_b (.en(op[0] & inB[N-1]), .a(inB), .y(abs_b));
  mdu_negate #(.W(2*N)) u_fix_prod (.en(psign_q), .a({acc_hi_q, acc_lo_q}), .y(prod_fix));
  mdu_negate #(.W(N)) u_fix_rem (.en(rsign_q), .a(acc_hi_q), .y(rem_fix));
  mdu_negate #(.W(N)) u_fix_quo (.en(psign_q), .a(acc_lo_q), .y(quo_fix));

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[N-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    psign_d  = psign_q;
    rsign_d  = rsign_q;
    divz_d   = divz_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          div_d    = op[1];
          psign_d  = op[0] & (inA[N-1] ^ inB[N-1]);
          rsign_d  = op[0] & inA[N-1];
          divz_d   = op[1] & (inB == '0);
          mcand_d  = op[1] ? abs_b : abs_a;
          acc_hi_d = '0;
          acc_lo_d = op[1] ? abs_a : abs_b;
          cnt_d    = '0;
          state_d  = MDU_CALC;
`ifdef MULT_DIV_EARLY_OUT_EN
          if (op[1] ? (inB == '0) : ((inA == '0) || (inB == '0))) begin
            // Load the already-known iteration result directly.
            acc_hi_d = op[1] ? abs_a : '0;
            acc_lo_d = '0;
            state_d  = MDU_SIGN;
          end
`endif
        end else begin
          if (hi_wen) hi_d = wd;
          if (lo_wen) lo_d = wd;
        end
      end
      MDU_CALC: begin
        if (div_q) begin
          if (!div_diff[N]) begin
            acc_hi_d = div_diff[N-1:0];
            acc_lo_d = {acc_lo_q[N-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[N-1:0];
            acc_lo_d = {acc_lo_q[N-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[N:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[N-1:1]};
        end
        if (cnt_q == CW'(N - 1)) begin
          state_d = MDU_SIGN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MDU_SIGN: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = divz_q ? '1 : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      psign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      divz_q   <= 1'b0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      psign_q  <= psign_d;
      rsign_q  <= rsign_d;
      divz_q   <= divz_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != MDU_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset && busy && (hi_wen || lo_wen)) begin
      $display("mult_div_unit warning: HI/LO move ignored while busy at time %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random ops vs arithmetic model,
// and hand sequences for busy-time requests, HI/LO moves and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] inA = '0, inB = '0, wd = '0;
  logic        hi_wen = 1'b0, lo_wen = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.N(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint unsigned up;
    longint          sp;
    int              sa, sb;
    case (o)
      MDU_MULTU: begin
        up = 64'(a) * 64'(b);
        {h, l} = up;
      end
      MDU_MULT: begin
        sp = longint'(signed'(a)) * longint'(signed'(b));
        {h, l} = sp;
      end
      MDU_DIVU: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      default: begin
        sa = signed'(a);
        sb = signed'(b);
        if (b == 0) begin l = '1; h = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = '0; end
        else begin l = sa / sb; h = sa % sb; end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_DIV_EARLY_OUT_EN
    if (o[1] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
    return 33;
  endfunction

  // Returns #1 after the start edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; op = o; inA = a; inB = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    inA = $urandom; inB = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!done && cyc < 100);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    launch(o, a, b);
    check({name, " busy"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check({name, " latency"}, 32'(cyc), 32'(exp_lat(o, a, b)));
    check({name, " busy@done"}, 32'(busy), 32'd0);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
  endtask

  vec_t vecs[13];

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, mh, ml;
    int          cyc;

    vecs[0]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{MDU_MULT,  32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{MDU_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7]  = '{MDU_DIVU,  32'd17,        32'd5,         32'd2,         32'd3};
    vecs[8]  = '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[9]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[10] = '{MDU_MULT,  32'd0,         32'h55,        32'd0,         32'd0};
    vecs[11] = '{MDU_DIVU,  32'd5,         32'd17,        32'd5,         32'd0};
    vecs[12] = '{MDU_MULTU, 32'd2,         32'd3,         32'd0,         32'd6};

    // Reset state
    #3;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) ra = 32'($urandom_range(0, 1)) << 31;
      model(ro, ra, rb, mh, ml);
      run_op($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb, mh, ml);
    end

    // start + mthi during busy are ignored, new operands not sampled
    launch(MDU_MULTU, 32'd3, 32'd4);
    repeat (4) begin @(posedge clock); #1; end
    start = 1'b1; op = MDU_DIVU; inA = 32'd99; inB = 32'd7; hi_wen = 1'b1; wd = 32'h1234;
    @(posedge clock);
    #1;
    start = 1'b0; hi_wen = 1'b0;
    wait_done(cyc);
    check("busy-ignore latency", 32'(cyc), 32'd28);
    check("busy-ignore hi", hi, 32'd0);
    check("busy-ignore lo", lo, 32'd12);
    @(posedge clock);
    #1;
    check("busy-ignore no restart", 32'(busy), 32'd0);

    // Idle mtlo / mthi
    @(negedge clock);
    lo_wen = 1'b1; wd = 32'h1234;
    @(posedge clock);
    #1;
    lo_wen = 1'b0;
    check("mtlo lo", lo, 32'h1234);
    check("mtlo hi", hi, 32'd0);
    @(negedge clock);
    hi_wen = 1'b1; wd = 32'hCAFE_0000;
    @(posedge clock);
    #1;
    hi_wen = 1'b0;
    check("mthi hi", hi, 32'hCAFE_0000);
    check("mthi lo", lo, 32'h1234);

    // Asynchronous reset in the middle of a divide
    launch(MDU_DIVU, 32'd1000, 32'd7);
    repeat (9) begin @(posedge clock); #1; end
    #1;
    reset = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset hi", hi, 32'd0);
    check("midreset lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op("post-reset divu", MDU_DIVU, 32'd17, 32'd5, 32'd2, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Takes the two register-file read operands, computes a 2N-bit product or quotient/remainder over N+1 cycles, and holds the results in the HI/LO registers.
- The writeback path and the pipeline stall logic consume `hi`/`lo` and `busy`.

Parameters:
- N, 32, operand width. Must be even and ≥ 4.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low. 0 clears all state immediately.
- start  input  1  request a new operation; sampled on posedge only while idle.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- inA  input  N  multiplicand / dividend (rs).
- inB  input  N  multiplier / divisor (rt).
- hi_wen  input  1  mthi: load HI from wd.
- lo_wen  input  1  mtlo: load LO from wd.
- wd  input  N  write data for mthi/mtlo.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse; `hi`/`lo` hold the new result.
- hi  output  N  HI register: product upper half, or remainder.
- lo  output  N  LO register: product lower half, or quotient.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter=0.
  - Reset mid-operation aborts the operation; no partial result is kept.
- **States:** IDLE, CALC, SIGN.
- **IDLE:**
  - start=1 at edge 0:
    - Capture op.
    - Capture operand magnitudes: absolute value if op[0]=1, else raw.
    - Record result signs: product/quotient sign = A^B; remainder sign = A.
    - Go to CALC, counter=0, busy=1, done=0.
  - start=0 with hi_wen or lo_wen: load HI/LO from wd at that edge.
  - start=1 together with hi_wen/lo_wen: start wins; the moves are ignored.
- **CALC, multiply (one iteration per edge, edges 1..N):**
  - Shift-add: if multiplier lsb=1, add multiplicand to the upper accumulator.
  - Shift the {carry, acc_hi, acc_lo} right by 1.
- **CALC, divide (one iteration per edge, edges 1..N):**
  - Restoring division: shift {rem, quo} left by 1.
  - Trial-subtract the divisor; if the result is non-negative, keep it and set quotient lsb=1.
- **CALC exit:** after the Nth iteration (counter==N-1), go to SIGN.
- **SIGN (edge N+1):**
  - Signed ops: two's-complement the result parts whose recorded sign is 1.
  - Write HI/LO, done<=1, busy<=0, state<=IDLE.
  - Latency: done is high for exactly the one cycle after edge N+1.
- **Arithmetic rules:**
  - The product is a full 2N-bit value with no truncation.
  - Division truncates toward zero; the remainder takes the dividend's sign.
- **Boundary conditions:**
  - Divide by zero (either signedness): lo = all ones, hi = inA; same latency.
  - DIV of -2^(N-1) by -1: lo = 0x80000000 (wraps), hi = 0.
  - MULT of -2^(N-1) by -2^(N-1): {hi,lo} = 0x40000000_00000000.
- **While busy:**
  - start, hi_wen and lo_wen are ignored; `hi`/`lo` hold their old values until SIGN.
  - hi_wen/lo_wen while busy print a $display warning with $time.
- **Operand changes:** inA/inB are not sampled after edge 0.

Optional Feature:
- Macro: MULT_DIV_EARLY_OUT_EN.
- **Defined:** in IDLE, if op is a multiply and either operand is 0, or op is a divide and inB is 0:
  - Skip CALC; go straight to SIGN.
  - done is high after edge 1; busy is high for one cycle.
  - Results are identical to the non-early-out case.
- **Undefined:** every operation takes the full N+1 cycles.

Decomposition:
- constants.h gains the op encodings MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV and the state encodings MDU_IDLE, MDU_CALC, MDU_SIGN.
- One sub-module, mdu_negate: parameterised N-bit conditional two's-complement, used in both operand capture and SIGN.

Test Plan:
- **MULTU:** inA=0xFFFFFFFF, inB=0xFFFFFFFF, start one cycle → busy 32+1 cycles; done pulse at edge 33; hi=0xFFFFFFFE, lo=0x00000001.
- **MULT:** inA=-7, inB=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6; DIV with inA=-7, inB=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **Divide boundaries:**
  - DIVU 100/0 → lo=0xFFFFFFFF, hi=100.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - Without the macro, both take 33 cycles.
- **Ignored requests while busy:** a second start plus hi_wen with wd=0x1234 at cycle 5 of a MULTU 3×4 → ignored and warning printed; result hi=0, lo=12; a later idle mtlo of 0x1234 → lo=0x1234.
- **Reset mid-operation:** reset low at cycle 10 of a DIVU → busy, done, hi, lo are 0 immediately (before the next edge); after release, start DIVU 17/5 → lo=3, hi=2.
- **Early out (MULT_DIV_EARLY_OUT_EN defined):** MULT 0×0x55 → done after edge 1, hi=lo=0; MULTU 2×3 still takes 33 cycles.
